branch_predict_unit: RTL

- Parametrised successor to the execute-stage branch-condition logic.
- Resolves RV32 conditional branches from full operand compares, with correct unsigned handling.
- Holds a direct-mapped table of saturating counters and targets that the fetch stage reads as a zero-latency prediction.
- Execute stage updates the table, flags mispredicts with the redirect PC, and keeps branch/mispredict statistics counters.

---
 rtl/branch_predict_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction for an RV32 pipeline.
// The fetch stage reads a direct-mapped table of saturating counters and
// targets with zero latency. The execute stage resolves conditional branches
// from full operand compares, trains the table, raises mispredict redirects
// and keeps saturating statistics counters.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int TAG_BITS  = 8,
  parameter int STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 if_pred_taken,
  output logic [XLEN-1:0]      if_pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [2:0]           ex_funct3,
  input  logic [XLEN-1:0]      ex_rs1,
  input  logic [XLEN-1:0]      ex_rs2,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  input  logic                 flush_table,
  output logic                 ex_taken,
  output logic                 ex_mispredict,
  output logic [XLEN-1:0]      ex_redirect_pc,
  output logic                 ex_illegal,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);

  // Counter encodings: weakly-not-taken is MSB 0 with the rest ones,
  // weakly-taken is MSB 1 with the rest zeros.
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic                tbl_valid  [ENTRIES];
  logic [TAG_BITS-1:0] tbl_tag    [ENTRIES];
  logic [XLEN-1:0]     tbl_target [ENTRIES];
  logic [CTR_BITS-1:0] tbl_ctr    [ENTRIES];

  logic [IDX-1:0]      if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX-1:0]      ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;

  logic resolve;
  logic cond;
  logic reserved;
  logic counted;

  // Only the index and tag fields of the PCs feed the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc};

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[IDX+TAG_BITS+1:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[IDX+TAG_BITS+1:IDX+2];
  assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

  // Zero-latency lookup reads the pre-update entry, so a same-cycle update
  // to the same index is only visible from the next cycle on.
  always_comb begin
    if_pred_taken  = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag)
                     && tbl_ctr[if_idx][CTR_BITS-1];
    if_pred_target = tbl_target[if_idx];
  end

  // Branch resolution; every execute output is forced low when no branch
  // is being resolved, and a reserved funct3 never counts as taken.
  always_comb begin
    resolve  = ex_valid && ex_is_branch;
    cond     = 1'b0;
    reserved = 1'b0;
    unique case (ex_funct3)
      3'b000:  cond = (ex_rs1 == ex_rs2);
      3'b001:  cond = (ex_rs1 != ex_rs2);
      3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond = (ex_rs1 <  ex_rs2);
      3'b111:  cond = (ex_rs1 >= ex_rs2);
      default: reserved = 1'b1;
    endcase
    counted        = resolve && !reserved;
    ex_illegal     = resolve && reserved;
    ex_taken       = counted && cond;
    ex_mispredict  = counted && ((ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    ex_redirect_pc = '0;
    if (resolve) ex_redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
  end

  // Table training; a flush wins over a same-cycle update and only drops
  // valid bits, keeping counters and targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= CTR_WNT;
      end
    end else if (flush_table) begin
      for (int i = 0; i < ENTRIES; i++) tbl_valid[i] <= 1'b0;
    end else if (counted) begin
      if (ex_hit) begin
        if (ex_taken) begin
          tbl_target[ex_idx] <= ex_target;
          if (tbl_ctr[ex_idx] != CTR_MAX) tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] + 1'b1;
        end else if (tbl_ctr[ex_idx] != '0) begin
          tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] - 1'b1;
        end
      end else if (ex_taken) begin
        tbl_valid[ex_idx]  <= 1'b1;
        tbl_tag[ex_idx]    <= ex_tag;
        tbl_target[ex_idx] <= ex_target;
        tbl_ctr[ex_idx]    <= CTR_WT;
      end
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (counted && (stat_branches != '1)) stat_branches <= stat_branches + 1'b1;
      if (ex_mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule
